// File: rtl/track_writeback.sv
// Flushes a dirty Apple II NIB track from track RAM back to the SD image via the hps_io sector interface.
// Optional idle auto-flush is compiled in with `define TRACK_WB_AUTOFLUSH_EN.
module track_writeback #(
  parameter int SECTORS           = 13,
  parameter int IDLE_FLUSH_CYCLES = 14318180
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        track_we,
  input  logic        flush_req,
  input  logic [5:0]  flush_track,
  input  logic        img_mounted,
  input  logic        img_size_nz,
  input  logic        img_readonly,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_din,
  output logic [12:0] tram_addr,
  input  logic [7:0]  tram_do,
  output logic        busy,
  output logic        flush_done,
  output logic        cpu_wait
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

  state_t      r_state, w_stateNext;
  logic        r_dirty, r_oldAck, r_sdWr, r_busy, r_flushDone, r_internal;
  logic [31:0] r_sdLba;
  logic [3:0]  r_sec;
  logic [5:0]  r_wtrack;

  logic        w_sdWrNext, w_busyNext, w_flushDoneNext, w_internalNext;
  logic [31:0] w_sdLbaNext;
  logic [3:0]  w_secNext;
  logic [5:0]  w_wtrackNext;
  logic        w_ackRise, w_ackFall, w_canWrite, w_dirtyClr, w_autoGo;
  logic [5:0]  w_autoTrack;

  assign w_ackRise  = sd_ack & ~r_oldAck;
  assign w_ackFall  = ~sd_ack & r_oldAck;
  assign w_canWrite = r_dirty & img_size_nz & ~img_readonly;

`ifdef TRACK_WB_AUTOFLUSH_EN
  localparam logic [23:0] QUIET_LAST = 24'(IDLE_FLUSH_CYCLES - 1);

  logic [23:0] r_quiet;
  logic [5:0]  r_autoTrack;
  logic        r_armed;

  // Quiet-time counter; the first write after a request re-latches the track in case the loader moved on.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_quiet     <= '0;
      r_autoTrack <= '0;
      r_armed     <= 1'b0;
    end else begin
      if (track_we || !r_dirty)
        r_quiet <= '0;
      else if (r_state == IDLE && r_quiet != QUIET_LAST)
        r_quiet <= r_quiet + 24'd1;
      if (r_state == IDLE && flush_req) begin
        r_autoTrack <= flush_track;
        r_armed     <= 1'b1;
      end else if (track_we && r_armed) begin
        r_autoTrack <= flush_track;
        r_armed     <= 1'b0;
      end
    end
  end

  assign w_autoGo    = (r_state == IDLE) & w_canWrite & (r_quiet == QUIET_LAST) & ~flush_req & ~track_we;
  assign w_autoTrack = r_autoTrack;
`else
  assign w_autoGo    = 1'b0;
  assign w_autoTrack = '0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:  if (flush_req)     w_stateNext = w_canWrite ? START : DONE;
             else if (w_autoGo) w_stateNext = START;
      START: w_stateNext = XFER;
      // A mount on the very cycle of the fall must not leave us waiting for an ack that never comes.
      XFER:  if (w_ackFall && (!r_sdWr || img_mounted)) w_stateNext = DONE;
      DONE:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_sdWrNext      = r_sdWr;
    w_busyNext      = r_busy;
    w_flushDoneNext = 1'b0;
    w_internalNext  = r_internal;
    w_sdLbaNext     = r_sdLba;
    w_secNext       = r_sec;
    w_wtrackNext    = r_wtrack;
    unique case (r_state)
      IDLE: begin
        if (flush_req) begin
          w_wtrackNext   = flush_track;
          w_internalNext = 1'b0;
        end else if (w_autoGo) begin
          w_wtrackNext   = w_autoTrack;
          w_internalNext = 1'b1;
        end
      end
      START: begin
        w_secNext   = '0;
        w_sdLbaNext = 32'(SECTORS) * 32'(r_wtrack);
        w_sdWrNext  = 1'b1;
        w_busyNext  = 1'b1;
      end
      XFER: begin
        if (w_ackRise) begin
          if (r_sec >= LAST_SEC) w_sdWrNext = 1'b0;
          w_sdLbaNext = r_sdLba + 32'd1;
        end
        if (w_ackFall) w_secNext = r_sec + 4'd1;
        if (img_mounted) w_sdWrNext = 1'b0;
      end
      DONE: begin
        w_flushDoneNext = ~r_internal;
        w_busyNext      = 1'b0;
      end
      default: ;
    endcase
  end

  // A write in the same cycle as any clear keeps the track dirty.
  assign w_dirtyClr = (r_state == START) | (r_state == IDLE & flush_req & ~w_canWrite) | img_mounted;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty     <= 1'b0;
      r_oldAck    <= 1'b0;
      r_sdWr      <= 1'b0;
      r_busy      <= 1'b0;
      r_flushDone <= 1'b0;
      r_internal  <= 1'b0;
      r_sdLba     <= '0;
      r_sec       <= '0;
      r_wtrack    <= '0;
    end else begin
      if (track_we)        r_dirty <= 1'b1;
      else if (w_dirtyClr) r_dirty <= 1'b0;
      r_oldAck    <= sd_ack;
      r_sdWr      <= w_sdWrNext;
      r_busy      <= w_busyNext;
      r_flushDone <= w_flushDoneNext;
      r_internal  <= w_internalNext;
      r_sdLba     <= w_sdLbaNext;
      r_sec       <= w_secNext;
      r_wtrack    <= w_wtrackNext;
    end
  end

  assign sd_lba      = r_sdLba;
  assign sd_wr       = r_sdWr;
  assign busy        = r_busy;
  assign cpu_wait    = r_busy;
  assign flush_done  = r_flushDone;
  assign tram_addr   = {r_sec, sd_buff_addr};
  assign sd_buff_din = tram_do;

endmodule
